setup_controller: RTL and testbench
===================================

Name: setup_controller

Overview:
- Sequences the lock's configuration menu while the operational FSM holds setup_on high.
- Walks the installer through seven items: bip_status, bip_time, tranca_aut_time, pin1..pin4. Keypad entries edit a working copy of the setup record.
- On exit, returns the record on data_setup_new and pulses setup_end for one cycle.
- master_pin is never edited here; it passes through unchanged.

Parameters:
- CLK_HZ, 1000, clock rate; all times are counted in clk cycles at this rate.
- TIMEOUT_S, 30, seconds of keypad inactivity before an automatic abort.
- TIME_MIN_S, 5, minimum legal bip/tranca time in seconds.
- TIME_MAX_S, 60, maximum legal bip/tranca time in seconds.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- setup_on  in  1  level request from the operational FSM; high = setup mode
- key_valid  in  1  keypad strobe, level; the block edge-detects it internally
- key_code  in  4  0-9 digit, 4'hA abort, 4'hE disable, 4'hF confirm
- data_setup_old  in  setupPac_t  current configuration
- data_setup_new  out  setupPac_t  edited configuration; valid while setup_end=1
- setup_end  out  1  one-cycle done pulse
- bcd_out  out  bcdPac_t  menu display
- bcd_enable  out  1  display enable

Behaviour:
- Keys act on the rising edge of key_valid only: key_valid=1 with key_valid_d=0.
- Reset values: state IDLE, data_setup_new=SETUP_DEFAULT, setup_end=0, bcd_out all 4'hF, bcd_enable=0, entry buffer empty, timeout counter 0.
- IDLE: on setup_on=1, go to LOAD.
- LOAD (1 cycle): work<=data_setup_old, item<=1, go to EDIT.
- EDIT, digit key:
  - Digit is appended to the buffer if count < max for the item (item 1: 1 digit; items 2-3: 2 digits; items 4-7: 4 digits).
  - Extra digits are ignored.
  - Item 1 accepts only digits 0 and 1; other digits are ignored.
- EDIT, F with an empty buffer: keep the old value and advance.
- EDIT, F with digits entered:
  - Item 1: bip_status<=digit.
  - Items 2-3: value v in seconds. If TIME_MIN_S<=v<=TIME_MAX_S, field<=v*CLK_HZ (16-bit) and advance. Otherwise reject: clear buffer, stay on item.
  - Items 4-7: exactly 4 digits sets pinN with status=1 and digit1..digit4 in entry order, then advance. 1-3 digits are rejected: clear buffer, stay.
- EDIT, E: on items 5-7, pinN.status<=0 and advance. E is ignored on items 1-4, so pin1 cannot be disabled.
- EDIT, A: work<=data_setup_old, go to DONE.
- Advance: clear buffer; item+1; after item 7, go to DONE.
- DONE (1 cycle): data_setup_new<=work, setup_end=1, go to WAIT.
- WAIT: hold data_setup_new; return to IDLE when setup_on=0.
- Timeout counter:
  - Cleared on every key edge and on entry to EDIT.
  - Increments while in EDIT.
  - At TIMEOUT_S*CLK_HZ-1 it acts exactly as A.
- setup_on falling while in LOAD or EDIT: go to IDLE immediately. No setup_end pulse; data_setup_new is unchanged.
- A key edge in the same cycle as the timeout terminal count: the key wins and the counter clears.
- Display:
  - bcd_enable=1 in LOAD, EDIT, DONE and WAIT.
  - bcd_out digit5=item number; digit4=4'hF; digits3..0=buffer contents from digit3 down, with unused digits 4'hF.
  - In IDLE, all digits are 4'hF.

Decomposition:
- Shared package lock_pkg:
  - pinPac_t {status, digit1..digit4}.
  - setupPac_t {bip_status, bip_time[15:0], tranca_aut_time[15:0], master_pin, pin1..pin4}.
  - bcdPac_t: six 4-bit digits, 4'hF=blank.
  - Key constants KEY_CONFIRM=4'hF, KEY_DISABLE=4'hE, KEY_ABORT=4'hA.
  - SETUP_DEFAULT: bip_status=1; times=5000; master=1234 with status 0; pin1=0000 with status 1; pins2-4 status 0.
- Sub-module setup_entry_buf: 4-digit entry buffer with count, append/clear controls, and a decimal value output (0-99) for the time items.

Test Plan:
- Reset mid-EDIT, then setup_on=1 and seven F keys -> setup_end pulses once; data_setup_new==data_setup_old; WAIT holds until setup_on=0.
- Item 2: key 1, key 0, F -> bip_time=10000. Item 3: key 3, F -> rejected, stays on item 3; then key 2, key 0, F -> tranca_aut_time=20000.
- Item 4: keys 9,8,7 then F -> rejected, buffer blank. Keys 9,8,7,6,5 then F -> pin1={1,9,8,7,6} (fifth digit ignored).
- E on item 4 -> no effect. E on item 6 -> pin3.status=0. Key_valid held high across two cycles -> a single digit is registered.
- Key A at item 5 after item 2 was edited -> setup_end pulses; data_setup_new equals data_setup_old (edit discarded).
- No keys for 30000 cycles in EDIT -> abort pulse at cycle 29999. A key at cycle 29999 -> no abort. setup_on dropped mid-EDIT -> IDLE with no setup_end.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the lock controller: PIN and setup records,
// the six-digit display bundle, keypad codes and the factory setup record.
package lock_pkg;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef struct packed {
    logic        bip_status;
    logic [15:0] bip_time;
    logic [15:0] tranca_aut_time;
    pinPac_t     master_pin;
    pinPac_t     pin1;
    pinPac_t     pin2;
    pinPac_t     pin3;
    pinPac_t     pin4;
  } setupPac_t;

  // Six BCD display digits, index 5 is the leftmost; 4'hF shows blank.
  typedef logic [5:0][3:0] bcdPac_t;

  localparam logic [3:0] KEY_CONFIRM = 4'hF;
  localparam logic [3:0] KEY_DISABLE = 4'hE;
  localparam logic [3:0] KEY_ABORT   = 4'hA;
  localparam logic [3:0] BCD_BLANK   = 4'hF;

  localparam setupPac_t SETUP_DEFAULT = '{
    bip_status:      1'b1,
    bip_time:        16'd5000,
    tranca_aut_time: 16'd5000,
    master_pin:      '{status: 1'b0, digit1: 4'd1, digit2: 4'd2, digit3: 4'd3, digit4: 4'd4},
    pin1:            '{status: 1'b1, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0},
    pin2:            '{status: 1'b0, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0},
    pin3:            '{status: 1'b0, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0},
    pin4:            '{status: 1'b0, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0}
  };

  // Converts a whole number of seconds into clock cycles, truncated to 16 bits.
  function automatic logic [15:0] secs_to_cycles(input logic [6:0] secs, input int clk_hz);
    return 16'(int'(secs) * clk_hz);
  endfunction

endpackage

// File: rtl/setup_entry_buf.sv
// Four-digit keypad entry buffer. Digits fill slot 0 first; unused slots read
// 4'hF so they display blank. Also presents the first one or two digits as a
// decimal value for the seconds-valued menu items.
module setup_entry_buf (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            append_i,
  input  logic [3:0]      digit_i,
  input  logic [2:0]      max_cnt_i,
  output logic [3:0][3:0] digits_o,
  output logic [2:0]      count_o,
  output logic [6:0]      value_o
);

  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       accept;

  // A digit is only taken while the item still has room for it.
  assign accept = append_i && (count_q < max_cnt_i);

  // Fill counter: cleared by clear_i, bumped on each accepted digit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 3'd0;
    end else if (accept) begin
      count_d = count_q + 3'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] digit_q;

    // Slot gi captures the digit that arrives while the count equals gi.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        digit_q <= 4'hF;
      end else if (clear_i) begin
        digit_q <= 4'hF;
      end else if (accept && (count_q == 3'(gi))) begin
        digit_q <= digit_i;
      end
    end

    assign digits_o[gi] = digit_q;
  end

  assign count_o = count_q;

  // Decimal value of a one- or two-digit entry (items never exceed two here).
  always_comb begin
    value_o = 7'd0;
    if (count_q == 3'd1) begin
      value_o = {3'b000, digits_o[0]};
    end else if (count_q >= 3'd2) begin
      value_o = ({3'b000, digits_o[0]} * 7'd10) + {3'b000, digits_o[1]};
    end
  end

endmodule

// File: rtl/setup_controller.sv
// Configuration menu sequencer. While setup_on is high it walks the installer
// through seven items (bip status, two times, four PINs), editing a working
// copy of the setup record, then hands the result back with a one-cycle
// setup_end pulse. Abort and keypad inactivity restore the incoming record.
module setup_controller
  import lock_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int TIMEOUT_S  = 30,
  parameter int TIME_MIN_S = 5,
  parameter int TIME_MAX_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setup_on,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  setupPac_t  data_setup_old,
  output setupPac_t  data_setup_new,
  output logic       setup_end,
  output bcdPac_t    bcd_out,
  output logic       bcd_enable
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_EDIT = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  localparam int TIMEOUT_CYC = TIMEOUT_S * CLK_HZ;
  localparam int TIMER_W     = $clog2(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [6:0] SECS_MIN = 7'(TIME_MIN_S);
  localparam logic [6:0] SECS_MAX = 7'(TIME_MAX_S);

  logic [2:0]         state_q, state_d;
  logic [2:0]         item_q, item_d;
  setupPac_t          work_q, work_d;
  setupPac_t          new_q, new_d;
  logic               end_q, end_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               key_valid_q;
  logic               key_edge;

  logic               buf_clear;
  logic               buf_append;
  logic [2:0]         buf_max;
  logic [3:0][3:0]    buf_digits;
  logic [2:0]         buf_count;
  logic [6:0]         buf_value;

  logic               advance;
  logic               abort;
  logic               time_ok;
  logic [15:0]        time_cyc;
  pinPac_t            entered_pin;

  assign key_edge = key_valid && !key_valid_q;

  setup_entry_buf u_entry_buf (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (buf_clear),
    .append_i  (buf_append),
    .digit_i   (key_code),
    .max_cnt_i (buf_max),
    .digits_o  (buf_digits),
    .count_o   (buf_count),
    .value_o   (buf_value)
  );

  // Digit capacity of the current item and the decoded forms of the entry.
  always_comb begin
    buf_max = 3'd4;
    if (item_q == 3'd1) begin
      buf_max = 3'd1;
    end else if (item_q <= 3'd3) begin
      buf_max = 3'd2;
    end
    time_ok     = (buf_value >= SECS_MIN) && (buf_value <= SECS_MAX);
    time_cyc    = secs_to_cycles(buf_value, CLK_HZ);
    entered_pin = '{status: 1'b1, digit1: buf_digits[0], digit2: buf_digits[1],
                    digit3: buf_digits[2], digit4: buf_digits[3]};
  end

  // Menu sequencing, key interpretation and inactivity timeout.
  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    work_d     = work_q;
    timer_d    = timer_q;
    buf_clear  = 1'b0;
    buf_append = 1'b0;
    advance    = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup_on) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!setup_on) begin
          state_d = ST_IDLE;
        end else begin
          work_d    = data_setup_old;
          item_d    = 3'd1;
          timer_d   = '0;
          buf_clear = 1'b1;
          state_d   = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (!setup_on) begin
          // Cancelled by the operational FSM: leave quietly, no result.
          buf_clear = 1'b1;
          state_d   = ST_IDLE;
        end else if (key_edge) begin
          // Any key press restarts the inactivity window, even at terminal count.
          timer_d = '0;
          if (key_code <= 4'd9) begin
            buf_append = (item_q != 3'd1) || (key_code <= 4'd1);
          end else if (key_code == KEY_CONFIRM) begin
            if (buf_count == 3'd0) begin
              advance = 1'b1;
            end else if (item_q == 3'd1) begin
              work_d.bip_status = buf_digits[0][0];
              advance           = 1'b1;
            end else if (item_q <= 3'd3) begin
              if (time_ok) begin
                if (item_q == 3'd2) begin
                  work_d.bip_time = time_cyc;
                end else begin
                  work_d.tranca_aut_time = time_cyc;
                end
                advance = 1'b1;
              end else begin
                buf_clear = 1'b1;
              end
            end else if (buf_count == 3'd4) begin
              case (item_q)
                3'd4:    work_d.pin1 = entered_pin;
                3'd5:    work_d.pin2 = entered_pin;
                3'd6:    work_d.pin3 = entered_pin;
                default: work_d.pin4 = entered_pin;
              endcase
              advance = 1'b1;
            end else begin
              buf_clear = 1'b1;
            end
          end else if (key_code == KEY_DISABLE) begin
            // pin1 is the fallback user PIN and can never be switched off.
            if (item_q >= 3'd5) begin
              case (item_q)
                3'd5:    work_d.pin2.status = 1'b0;
                3'd6:    work_d.pin3.status = 1'b0;
                default: work_d.pin4.status = 1'b0;
              endcase
              advance = 1'b1;
            end
          end else if (key_code == KEY_ABORT) begin
            abort = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end

        if (advance) begin
          buf_clear = 1'b1;
          if (item_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            item_d = item_q + 3'd1;
          end
        end
        if (abort) begin
          work_d    = data_setup_old;
          buf_clear = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!setup_on) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result publication: the record and the pulse leave DONE together.
  always_comb begin
    end_d = (state_q == ST_DONE);
    new_d = (state_q == ST_DONE) ? work_q : new_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      item_q      <= 3'd0;
      work_q      <= SETUP_DEFAULT;
      new_q       <= SETUP_DEFAULT;
      end_q       <= 1'b0;
      timer_q     <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_q      <= item_d;
      work_q      <= work_d;
      new_q       <= new_d;
      end_q       <= end_d;
      timer_q     <= timer_d;
      key_valid_q <= key_valid;
    end
  end

  // Display: item number on the left, blank, then the entered digits.
  always_comb begin
    bcd_out    = {6{BCD_BLANK}};
    bcd_enable = (state_q != ST_IDLE);
    if (state_q != ST_IDLE) begin
      bcd_out[5] = {1'b0, item_q};
      bcd_out[3] = buf_digits[0];
      bcd_out[2] = buf_digits[1];
      bcd_out[1] = buf_digits[2];
      bcd_out[0] = buf_digits[3];
    end
  end

  assign data_setup_new = new_q;
  assign setup_end      = end_q;

endmodule

// File: tb/tb_setup_controller.sv
// Bench for setup_controller: a menu-level reference model runs alongside the
// DUT and is compared every cycle; directed sequences add literal checks.
module tb_setup_controller;
  import lock_pkg::*;

  localparam int TIMEOUT_CYC = 30 * 1000;

  logic       clk;
  logic       rst;
  logic       setup_on;
  logic       key_valid;
  logic [3:0] key_code;
  setupPac_t  data_setup_old;
  setupPac_t  data_setup_new;
  logic       setup_end;
  bcdPac_t    bcd_out;
  logic       bcd_enable;

  setup_controller dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .data_setup_old (data_setup_old),
    .data_setup_new (data_setup_new),
    .setup_end      (setup_end),
    .bcd_out        (bcd_out),
    .bcd_enable     (bcd_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int end_pulses = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic pinPac_t mkpin(input logic s, input logic [3:0] a, input logic [3:0] b,
                                    input logic [3:0] c, input logic [3:0] d);
    pinPac_t p;
    p.status = s; p.digit1 = a; p.digit2 = b; p.digit3 = c; p.digit4 = d;
    return p;
  endfunction

  function automatic setupPac_t factory_record();
    setupPac_t r;
    r.bip_status = 1'b1; r.bip_time = 16'd5000; r.tranca_aut_time = 16'd5000;
    r.master_pin = mkpin(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
    r.pin1 = mkpin(1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    r.pin2 = mkpin(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    r.pin3 = mkpin(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    r.pin4 = mkpin(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    return r;
  endfunction

  // ---------------- reference model (menu level) ----------------
  typedef enum {M_IDLE, M_LOAD, M_EDIT, M_DONE, M_WAIT} mmode_t;
  mmode_t    m_mode;
  int        m_item;
  int        m_buf[$];
  int        m_idle;
  setupPac_t m_work;
  setupPac_t m_new;
  logic      m_end;
  logic      m_kv_prev;

  task automatic model_reset();
    m_mode = M_IDLE; m_item = 0; m_buf.delete(); m_idle = 0;
    m_work = factory_record(); m_new = factory_record(); m_end = 1'b0; m_kv_prev = 1'b0;
  endtask

  task automatic model_advance();
    m_buf.delete();
    if (m_item == 7) m_mode = M_DONE;
    else m_item = m_item + 1;
  endtask

  task automatic model_abort();
    m_work = data_setup_old;
    m_buf.delete();
    m_mode = M_DONE;
  endtask

  task automatic model_key(input int k);
    int maxd;
    int v;
    pinPac_t p;
    maxd = (m_item == 1) ? 1 : ((m_item <= 3) ? 2 : 4);
    if (k <= 9) begin
      if (m_buf.size() < maxd && (m_item != 1 || k <= 1)) m_buf.push_back(k);
    end else if (k == 15) begin
      if (m_buf.size() == 0) model_advance();
      else if (m_item == 1) begin
        m_work.bip_status = (m_buf[0] == 1);
        model_advance();
      end else if (m_item <= 3) begin
        v = 0;
        foreach (m_buf[i]) v = v * 10 + m_buf[i];
        if (v >= 5 && v <= 60) begin
          if (m_item == 2) m_work.bip_time = 16'(v * 1000);
          else m_work.tranca_aut_time = 16'(v * 1000);
          model_advance();
        end else m_buf.delete();
      end else if (m_buf.size() == 4) begin
        p = mkpin(1'b1, 4'(m_buf[0]), 4'(m_buf[1]), 4'(m_buf[2]), 4'(m_buf[3]));
        case (m_item)
          4: m_work.pin1 = p;
          5: m_work.pin2 = p;
          6: m_work.pin3 = p;
          default: m_work.pin4 = p;
        endcase
        model_advance();
      end else m_buf.delete();
    end else if (k == 14) begin
      if (m_item >= 5) begin
        case (m_item)
          5: m_work.pin2.status = 1'b0;
          6: m_work.pin3.status = 1'b0;
          default: m_work.pin4.status = 1'b0;
        endcase
        model_advance();
      end
    end else if (k == 10) begin
      model_abort();
    end
  endtask

  task automatic model_step();
    logic edge_seen;
    edge_seen = key_valid && !m_kv_prev;
    m_kv_prev = key_valid;
    m_end = 1'b0;
    case (m_mode)
      M_IDLE: if (setup_on) m_mode = M_LOAD;
      M_LOAD: begin
        if (!setup_on) m_mode = M_IDLE;
        else begin
          m_work = data_setup_old; m_item = 1; m_buf.delete(); m_idle = 0; m_mode = M_EDIT;
        end
      end
      M_EDIT: begin
        if (!setup_on) begin
          m_mode = M_IDLE; m_buf.delete();
        end else if (edge_seen) begin
          m_idle = 0;
          model_key(int'(key_code));
        end else if (m_idle == TIMEOUT_CYC - 1) model_abort();
        else m_idle = m_idle + 1;
      end
      M_DONE: begin
        m_new = m_work; m_end = 1'b1; m_mode = M_WAIT;
      end
      default: if (!setup_on) m_mode = M_IDLE;
    endcase
  endtask

  function automatic bcdPac_t model_bcd();
    bcdPac_t b;
    b = {6{4'hF}};
    if (m_mode == M_EDIT) begin
      b[5] = 4'(m_item);
      for (int i = 0; i < m_buf.size(); i++) b[3 - i] = 4'(m_buf[i]);
    end
    return b;
  endfunction

  // Model advance on each rising edge; comparison on each falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      if (rst) model_reset();
      check("bcd_enable", bcd_enable, m_mode != M_IDLE);
      check("setup_end", setup_end, m_end);
      check("data_setup_new", data_setup_new, m_new);
      if (m_mode == M_IDLE || m_mode == M_EDIT) check("bcd_out", bcd_out, model_bcd());
      if (setup_end === 1'b1) end_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code);
    key_code = code; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    $display("key %h -> display %h end=%b", code, bcd_out, setup_end);
  endtask

  task automatic press_hold(input logic [3:0] code);
    key_code = code; key_valid = 1'b1;
    tick(2);
    key_valid = 1'b0;
    tick();
    $display("key %h (held) -> display %h", code, bcd_out);
  endtask

  task automatic wait_end(input int budget, output int waited);
    logic found;
    found = 1'b0;
    waited = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (setup_end === 1'b1) begin
        waited = i; found = 1'b1;
        break;
      end
    end
    check("setup_end_seen", found, 1'b1);
    $display("setup_end after %0d cycles, record %h", waited, data_setup_new);
  endtask

  setupPac_t old_a, old_b, exp2;
  int w;

  initial begin
    old_a.bip_status = 1'b0; old_a.bip_time = 16'd7000; old_a.tranca_aut_time = 16'd9000;
    old_a.master_pin = mkpin(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    old_a.pin1 = mkpin(1'b1, 4'd5, 4'd5, 4'd5, 4'd5);
    old_a.pin2 = mkpin(1'b1, 4'd1, 4'd1, 4'd2, 4'd2);
    old_a.pin3 = mkpin(1'b1, 4'd3, 4'd3, 4'd4, 4'd4);
    old_a.pin4 = mkpin(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    old_b = old_a;
    old_b.bip_time = 16'd8000;
    old_b.pin2.status = 1'b0;
    exp2 = old_a;
    exp2.bip_status = 1'b1; exp2.bip_time = 16'd10000; exp2.tranca_aut_time = 16'd20000;
    exp2.pin1 = mkpin(1'b1, 4'd9, 4'd8, 4'd7, 4'd6);
    exp2.pin3 = mkpin(1'b0, 4'd3, 4'd3, 4'd4, 4'd4);
    exp2.pin4 = mkpin(1'b1, 4'd2, 4'd3, 4'd4, 4'd5);

    rst = 1'b1; setup_on = 1'b0; key_valid = 1'b0; key_code = 4'd0; data_setup_old = old_a;
    tick(3);
    check("reset_setup_end", setup_end, 1'b0);
    check("reset_bcd_enable", bcd_enable, 1'b0);
    check("reset_bcd_out", bcd_out, 24'hFFFFFF);
    check("reset_record", data_setup_new, factory_record());
    rst = 1'b0;

    // Reset in the middle of editing, then seven confirms keep everything.
    setup_on = 1'b1;
    tick(3);
    press(4'd1);
    check("t1_item1_entry", bcd_out, 24'h1F1FFF);
    rst = 1'b1;
    #2;
    check("t1_async_reset_enable", bcd_enable, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(3);
    repeat (7) press(KEY_CONFIRM);
    wait_end(10, w);
    check("t1_record_unchanged", data_setup_new, old_a);
    tick(5);
    check("t1_wait_hold_end", setup_end, 1'b0);
    check("t1_wait_hold_record", data_setup_new, old_a);
    check("t1_wait_enable", bcd_enable, 1'b1);
    setup_on = 1'b0;
    tick(2);
    check("t1_back_idle", bcd_enable, 1'b0);
    check("t1_pulses", end_pulses, 1);

    // Full edit pass with rejections and boundary behaviour.
    setup_on = 1'b1;
    tick(3);
    press(4'd7);
    check("t2_item1_digit7_ignored", bcd_out, 24'h1FFFFF);
    press(4'd1); press(KEY_CONFIRM);
    press(4'd1); press(4'd0); press(KEY_CONFIRM);
    press(4'd3); press(KEY_CONFIRM);
    check("t2_item3_reject", bcd_out, 24'h3FFFFF);
    press(4'd2); press(4'd0); press(KEY_CONFIRM);
    press(4'd9); press(4'd8); press(4'd7); press(KEY_CONFIRM);
    check("t2_item4_short_reject", bcd_out, 24'h4FFFFF);
    press(KEY_DISABLE);
    check("t2_item4_disable_ignored", bcd_out, 24'h4FFFFF);
    press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
    check("t2_item4_fifth_ignored", bcd_out, 24'h4F9876);
    press(KEY_CONFIRM);
    press(KEY_CONFIRM);
    press(KEY_DISABLE);
    check("t2_item7_reached", bcd_out, 24'h7FFFFF);
    press_hold(4'd2);
    check("t2_held_key_single", bcd_out, 24'h7F2FFF);
    press(4'd3); press(4'd4); press(4'd5); press(KEY_CONFIRM);
    wait_end(10, w);
    check("t2_record", data_setup_new, exp2);
    setup_on = 1'b0;
    tick(2);
    check("t2_pulses", end_pulses, 2);

    // Abort at item 5 discards an earlier edit.
    setup_on = 1'b1;
    tick(3);
    press(KEY_CONFIRM);
    press(4'd1); press(4'd5); press(KEY_CONFIRM);
    press(KEY_CONFIRM); press(KEY_CONFIRM);
    check("t3_at_item5", bcd_out, 24'h5FFFFF);
    press(KEY_ABORT);
    wait_end(10, w);
    check("t3_abort_record", data_setup_new, old_a);
    setup_on = 1'b0;
    tick(2);
    check("t3_pulses", end_pulses, 3);

    // Inactivity timeout restores the (changed) incoming record.
    data_setup_old = old_b;
    setup_on = 1'b1;
    tick(3);
    press(KEY_CONFIRM);
    press(4'd1); press(4'd0); press(KEY_CONFIRM);
    wait_end(TIMEOUT_CYC + 100, w);
    check("t4_timeout_latency", w, 30000);
    check("t4_timeout_record", data_setup_new, old_b);
    setup_on = 1'b0;
    tick(2);
    check("t4_pulses", end_pulses, 4);

    // Key at the terminal count wins; then setup_on drops mid-edit.
    setup_on = 1'b1;
    tick(3);
    press(4'd0);
    tick(TIMEOUT_CYC - 2);
    press(4'd5);
    tick(40);
    check("t5_no_abort", end_pulses, 4);
    check("t5_still_editing", bcd_out, 24'h1F0FFF);
    setup_on = 1'b0;
    tick(3);
    check("t5_drop_idle", bcd_enable, 1'b0);
    check("t5_drop_no_pulse", end_pulses, 4);
    check("t5_drop_record", data_setup_new, old_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
